// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 raster timing shared by the sync generator and display datapath
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int HS_END = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int VS_END = VS_START + DEF_V_SYNC;
  localparam int CNT_W = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;
  // one spare bit so window bounds equal to 1024 still compare correctly
  typedef logic [CNT_W:0] ext_t;
  function automatic logic in_window(input ext_t val, input ext_t lo, input ext_t hi);
    return val >= lo && val < hi;
  endfunction
endpackage

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter: enabled modulo counter exposing its next value and a wrap strobe
module vga_wrap_counter #(
  parameter int W = 10,
  parameter int MAX = 799
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] next,
  output logic         wrap
);
  logic [W-1:0] count;
  assign wrap = en && count == W'(MAX);
  assign next = !en ? count : wrap ? '0 : count + 1'b1;
  // resets to MAX so the first enable lands on 0 with a wrap strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count <= W'(MAX);
    else count <= next;
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator producing syncs, active-video, coordinates and strobes
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam ext_t HA = ext_t'(H_ACTIVE);
  localparam ext_t VA = ext_t'(V_ACTIVE);
  localparam ext_t HSS = ext_t'(H_ACTIVE + H_FP);
  localparam ext_t HSE = ext_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam ext_t VSS = ext_t'(V_ACTIVE + V_FP);
  localparam ext_t VSE = ext_t'(V_ACTIVE + V_FP + V_SYNC);
  if (HT > MAX_TOTAL || VT > MAX_TOTAL) begin : g_bad_timing
    $error("vga_sync_gen: line/frame totals must not exceed %0d", MAX_TOTAL);
  end
  logic [CNT_W-1:0] h_next, v_next;
  logic h_wrap, v_wrap;
  ext_t hx, vx;
  vga_wrap_counter #(.W(CNT_W), .MAX(HT - 1)) u_h (
    .clock(clock), .reset(reset), .en(pixel_tick), .next(h_next), .wrap(h_wrap)
  );
  vga_wrap_counter #(.W(CNT_W), .MAX(VT - 1)) u_v (
    .clock(clock), .reset(reset), .en(h_wrap), .next(v_next), .wrap(v_wrap)
  );
  assign hx = {1'b0, h_next};
  assign vx = {1'b0, v_next};
  // decoding the next-state counts keeps every registered output aligned with pixel_x/pixel_y
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      display_on <= 1'b0;
      pixel_x <= '0;
      pixel_y <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start <= h_wrap;
      frame_start <= v_wrap;
      if (pixel_tick) begin
        pixel_x <= h_next;
        pixel_y <= v_next;
        display_on <= hx < HA && vx < VA;
        hsync <= in_window(hx, HSS, HSE) ? SYNC_POL : ~SYNC_POL;
        vsync <= in_window(vx, VSS, VSE) ? SYNC_POL : ~SYNC_POL;
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for a default-timing instance and a tiny active-high-sync instance
module tb_vga_sync_gen;
  typedef struct packed {
    logic hs; logic vs; logic de; logic [9:0] x; logic [9:0] y; logic ls; logic fs;
  } obs_t;
  typedef struct {int h; int v; obs_t o;} mdl_t;
  typedef struct {int ha; int hfp; int hs; int hbp; int va; int vfp; int vs; int vbp; bit pol;} tim_t;

  logic clock = 0, reset = 1, pixel_tick = 0;
  logic a_hs, a_vs, a_de, a_ls, a_fs, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [9:0] a_x, a_y, b_x, b_y;
  obs_t a_obs, b_obs;
  obs_t qa[$], qb[$];
  mdl_t ma, mb;
  tim_t ta = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
  tim_t tb = '{8, 2, 3, 2, 6, 2, 2, 3, 1'b1};
  int total = 0, bad = 0, cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  vga_sync_gen dut_a (
    .clock(clock), .reset(reset), .pixel_tick(pixel_tick), .hsync(a_hs), .vsync(a_vs),
    .display_on(a_de), .pixel_x(a_x), .pixel_y(a_y), .line_start(a_ls), .frame_start(a_fs)
  );
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) dut_b (
    .clock(clock), .reset(reset), .pixel_tick(pixel_tick), .hsync(b_hs), .vsync(b_vs),
    .display_on(b_de), .pixel_x(b_x), .pixel_y(b_y), .line_start(b_ls), .frame_start(b_fs)
  );
  assign a_obs = {a_hs, a_vs, a_de, a_x, a_y, a_ls, a_fs};
  assign b_obs = {b_hs, b_vs, b_de, b_x, b_y, b_ls, b_fs};

  function automatic mdl_t m_reset(tim_t t);
    mdl_t m;
    m.h = t.ha + t.hfp + t.hs + t.hbp - 1;
    m.v = t.va + t.vfp + t.vs + t.vbp - 1;
    m.o = '0;
    m.o.hs = !t.pol;
    m.o.vs = !t.pol;
    return m;
  endfunction

  function automatic mdl_t m_adv(mdl_t mi, tim_t t, bit tick);
    mdl_t m = mi;
    int ht = t.ha + t.hfp + t.hs + t.hbp;
    int vt = t.va + t.vfp + t.vs + t.vbp;
    bit hw;
    m.o.ls = 0;
    m.o.fs = 0;
    if (tick) begin
      hw = (m.h == ht - 1);
      m.h = hw ? 0 : m.h + 1;
      if (hw) begin
        m.o.fs = (m.v == vt - 1);
        m.v = m.o.fs ? 0 : m.v + 1;
      end
      m.o.ls = hw;
      m.o.x = 10'(m.h);
      m.o.y = 10'(m.v);
      m.o.de = m.h < t.ha && m.v < t.va;
      m.o.hs = (m.h >= t.ha + t.hfp && m.h < t.ha + t.hfp + t.hs) ? t.pol : !t.pol;
      m.o.vs = (m.v >= t.va + t.vfp && m.v < t.va + t.vfp + t.vs) ? t.pol : !t.pol;
    end
    return m;
  endfunction

  task automatic cmp_obs(string nm, obs_t act, obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
               nm, cyc, act.hs, act.vs, act.de, act.x, act.y, act.ls, act.fs,
               exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.ls, exp.fs);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (qa.size() > 0) cmp_obs("sb_a", a_obs, qa.pop_front());
    if (qb.size() > 0) cmp_obs("sb_b", b_obs, qb.pop_front());
  end

  task automatic step(bit tick);
    pixel_tick = tick;
    @(posedge clock);
    #1;
    ma = reset ? m_reset(ta) : m_adv(ma, ta, tick);
    mb = reset ? m_reset(tb) : m_adv(mb, tb, tick);
    qa.push_back(ma.o);
    qb.push_back(mb.o);
    pixel_tick = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs_n, last;
    bit found;
    ma = m_reset(ta);
    mb = m_reset(tb);
    repeat (3) step(0);
    reset = 0;
    repeat (20) step(0);
    chk("idle_hs", a_hs, 1);
    chk("idle_vs", a_vs, 1);
    chk("idle_de", a_de, 0);
    chk("idle_x", a_x, 0);
    step(1);
    chk("first_x", a_x, 0);
    chk("first_y", a_y, 0);
    chk("first_de", a_de, 1);
    chk("first_ls", a_ls, 1);
    chk("first_fs", a_fs, 1);
    step(1);
    chk("second_x", a_x, 1);
    chk("second_ls", a_ls, 0);
    chk("second_fs", a_fs, 0);
    for (int n = 3; n <= 1602; n++) begin
      step(1);
      if (n == 640) chk("de_639", a_de, 1);
      if (n == 641) chk("de_640", a_de, 0);
      if (n == 656) chk("hs_655", a_hs, 1);
      if (n == 657) chk("hs_656", a_hs, 0);
      if (n == 752) chk("hs_751", a_hs, 0);
      if (n == 753) chk("hs_752", a_hs, 1);
      if (n == 801) begin
        chk("wrap_x", a_x, 0);
        chk("wrap_y", a_y, 1);
        chk("wrap_ls", a_ls, 1);
        chk("wrap_fs", a_fs, 0);
      end
      if (n == 802) chk("wrap_ls_off", a_ls, 0);
    end
    fs_n = 0;
    last = -1;
    for (int i = 0; i < 585; i++) begin
      step(1);
      if (b_fs) begin
        fs_n++;
        if (last >= 0) chk("b_frame_period", cyc - last, 1560);
        last = cyc;
      end
      repeat (7) step(0);
    end
    chk("b_frame_count", fs_n, 3);
    for (int i = 0; i < 300; i++) begin
      step(1);
      repeat ($urandom_range(0, 5)) step(0);
    end
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1);
      found = mb.h >= 10 && mb.h <= 12 && mb.v >= 8 && mb.v <= 9;
    end
    chk("b_sync_window_found", int'(found), 1);
    chk("b_hs_asserted", b_hs, 1);
    chk("b_vs_asserted", b_vs, 1);
    @(negedge clock);
    #1;
    reset = 1;
    #1;
    chk("rst_b_hs", b_hs, 0);
    chk("rst_b_vs", b_vs, 0);
    chk("rst_a_hs", a_hs, 1);
    chk("rst_a_vs", a_vs, 1);
    chk("rst_a_de", a_de, 0);
    chk("rst_b_x", b_x, 0);
    repeat (2) step(0);
    reset = 0;
    step(0);
    step(1);
    chk("post_rst_a_x", a_x, 0);
    chk("post_rst_a_y", a_y, 0);
    chk("post_rst_a_fs", a_fs, 1);
    chk("post_rst_b_fs", b_fs, 1);
    chk("post_rst_b_de", b_de, 1);
    step(1);
    chk("post_rst2_b_x", b_x, 1);
    chk("post_rst2_b_fs", b_fs, 0);
    repeat (2) @(negedge clock);
    chk("queue_drain", qa.size() + qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
